dsp_mult_arbiter: RTL and testbench
===================================

Name: dsp_mult_arbiter

Overview:
- Shares one pipelined signed multiplier between the DSP stages that need multiplies: magnitude squares and FIR MACs now, resampling later.
- Arbitration is round-robin with an optional bounded burst lock, so the FIR can stream a tap sequence.
- Products return in issue order, tagged to the requester that issued them.
- Runs on the main DSP clock alongside the magnitude, moving-average and FIR stages.

Parameters:
- NUM_REQ, 2, number of requesters; index 0 is highest priority after reset.
- REQ_ID_BITS, 1, width of the requester index; equals clog2(NUM_REQ), minimum 1.
- OPERAND_BITS, 18, signed operand width.
- PRODUCT_BITS, 36, product width; always 2*OPERAND_BITS.
- MULT_LATENCY, 3, cycles from the grant cycle to product_valid; minimum 1.
- MAX_BURST, 64, maximum consecutive grants to one locked requester.
- BURST_BITS, 7, burst counter width; holds MAX_BURST.

Ports:
- clk  in  1  DSP clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester multiply request
- lock  in  NUM_REQ  per-requester request to keep the grant next cycle
- op_a  in  NUM_REQ x OPERAND_BITS  signed operand A per requester
- op_b  in  NUM_REQ x OPERAND_BITS  signed operand B per requester
- grant  out  NUM_REQ  one-hot (or zero); combinational from req, lock and state
- product  out  PRODUCT_BITS  shared signed product bus
- product_valid  out  NUM_REQ  one-hot strobe marking the owner of product
- busy  out  1  high while any product is in flight in the pipeline

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high.
  - rr_ptr=0, locked=0, burst_cnt=0.
  - All pipeline valid bits cleared; product=0, product_valid=0, busy=0.
  - grant=0 during the reset cycle.
- Reset mid-operation: in-flight products are discarded. No product_valid is asserted for any operation issued before reset.
- Handshake:
  - A request is accepted on the cycle where req[i]&&grant[i].
  - op_a[i] and op_b[i] are sampled in that same cycle.
  - The requester holds req and its operands stable until granted.
  - If req stays high after a grant, that is a new request. Back-to-back issue at one per cycle is allowed.
- Arbitration (no active lock):
  - grant the first i with req[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - On a grant to i: rr_ptr <= (i+1) mod NUM_REQ.
  - No requests: grant=0 and rr_ptr is unchanged.
- Burst lock:
  - If granted i has lock[i]=1, then locked<=1, owner<=i, burst_cnt increments.
  - While locked, grant goes only to owner, and only if req[owner]=1. Other requests wait.
  - The lock releases when lock[owner]=0 at a grant, when req[owner]=0 (idle cycle, no grant), or when burst_cnt reaches MAX_BURST.
  - On release, burst_cnt<=0 and normal round-robin resumes from (owner+1) mod NUM_REQ.
  - The MAX_BURST-th consecutive grant is the last one. The next cycle arbitrates normally.
- Datapath:
  - Issue register captures op_a/op_b of the granted index plus the requester id and a valid bit.
  - A full-precision signed multiply follows, pipelined to total MULT_LATENCY stages.
  - The id and valid bits travel in a shift register of the same depth.
- Latency: grant in cycle t gives product_valid[id]=1 with product in cycle t+MULT_LATENCY, for exactly one cycle.
- Between results: product holds the last value; product_valid=0.
- Ordering: results come out in issue order. No reordering and no backpressure; requesters must accept results.
- Arithmetic: the most negative value times itself gives +2^(2*OPERAND_BITS-2); PRODUCT_BITS is wide enough, so nothing saturates.
- Simultaneous events: all-request contention is resolved by rr_ptr alone. A lock request from a requester that is not granted has no effect.

Decomposition:
- Shared package dsp_pkg:
  - mult_req_t struct {valid, id, a, b}.
  - Constants DSP_OPERAND_BITS=18 and DSP_MULT_LATENCY=3.
  - Function rr_pick(req, ptr) returning a one-hot grant.
- One sub-module, mult_pipe: signed multiplier with the id/valid sideband shift register, parameterized by OPERAND_BITS and MULT_LATENCY.
- Arbitration and lock FSM (states UNLOCKED, LOCKED) stay in dsp_mult_arbiter.

Test Plan:
- Single request: req[0]=1, a=3, b=-5 at t0 -> grant[0]=1 at t0; product=-15 and product_valid=2'b01 at t0+3; busy high t0+1..t0+3.
- Contention, no lock, both req held 4 cycles after reset -> grants 0,1,0,1; four products return in that order with matching product_valid ids.
- Burst, MAX_BURST=4: req=2'b11, lock[1]=1, rr_ptr=1 -> grant[1] on 4 consecutive cycles, then grant[0]; requester 0 waits exactly 4 cycles.
- Lock release by deassert: locked owner 0 drops lock on its 2nd grant -> next cycle grants requester 1.
- Extremes: a=b=-131072 -> product=+17179869184 (0x4_0000_0000) after 3 cycles; a=131071, b=-131072 -> -17179738112.
- Reset mid-flight: issue 3 ops, assert rst for 1 cycle after the 2nd -> no product_valid afterward, grant=0 during rst, rr_ptr=0 on the next contention.

Source files
------------

// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_pkg
//  Description : Shared types, constants and helpers for the DSP multiply
//                path: the multiply request bundle, default operand width
//                and multiplier latency, and the round-robin picker used by
//                dsp_mult_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package dsp_pkg;

    localparam int unsigned DSP_OPERAND_BITS     = 18;
    localparam int unsigned DSP_MULT_LATENCY     = 3;
    localparam int unsigned DSP_REQ_ID_BITS      = 1;

    // Upper bound on requesters the picker can handle; callers zero-extend
    // their request vector to this width and truncate the result.
    localparam int unsigned DSP_MAX_REQ          = 16;
    localparam int unsigned DSP_MAX_REQ_IDX_BITS = 4;

    typedef struct packed {
        logic                               valid;
        logic [DSP_REQ_ID_BITS-1:0]         id;
        logic signed [DSP_OPERAND_BITS-1:0] a;
        logic signed [DSP_OPERAND_BITS-1:0] b;
    } mult_req_t;

    // One-hot pick of the first set bit of req[n-1:0], searching upward from
    // ptr and wrapping at n. Returns zero when nothing is requested.
    function automatic logic [DSP_MAX_REQ-1:0] rr_pick(
        input logic [DSP_MAX_REQ-1:0] req,
        input int unsigned            ptr,
        input int unsigned            n
    );
        logic [DSP_MAX_REQ-1:0] pick;
        logic                   found;
        int unsigned            idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DSP_MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (i < n) && req[idx[DSP_MAX_REQ_IDX_BITS-1:0]]) begin
                pick[idx[DSP_MAX_REQ_IDX_BITS-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pipe
//  Description : Full-precision signed multiplier with an id/valid sideband
//                shift register of equal depth. The first stage is the issue
//                register; a result appears MULT_LATENCY cycles after
//                in_valid. The product output holds its last value between
//                results.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                in_valid/in_id      issue strobe and requester id
//                in_a, in_b          signed operands
//                product             registered signed product
//                out_valid/out_id    result strobe and its requester id
//                busy                any operation in flight
//  Revision    : 1.0  initial release
// ============================================================================
module mult_pipe
    import dsp_pkg::*;
#(
    parameter int unsigned OPERAND_BITS = DSP_OPERAND_BITS,
    parameter int unsigned MULT_LATENCY = DSP_MULT_LATENCY,
    parameter int unsigned ID_BITS      = DSP_REQ_ID_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [ID_BITS-1:0]             in_id,
    input  logic signed [OPERAND_BITS-1:0] in_a,
    input  logic signed [OPERAND_BITS-1:0] in_b,
    output logic signed [2*OPERAND_BITS-1:0] product,
    output logic                           out_valid,
    output logic [ID_BITS-1:0]             out_id,
    output logic                           busy
);

    localparam int unsigned PW = 2 * OPERAND_BITS;

    logic [MULT_LATENCY-1:0]              r_vld;
    logic [MULT_LATENCY-1:0][ID_BITS-1:0] r_id;
    logic signed [PW-1:0]                 r_product;

    // Sideband: valid is reset so a mid-flight reset drops every pending
    // result; ids need no reset because they are qualified by valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= in_valid;
            for (int unsigned k = 1; k < MULT_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_id[0] <= in_id;
        for (int unsigned k = 1; k < MULT_LATENCY; k++) begin
            r_id[k] <= r_id[k-1];
        end
    end

    generate
        if (MULT_LATENCY == 1) begin : g_lat1
            // Single stage: multiply straight from the issuing operands.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_product <= '0;
                end else if (in_valid) begin
                    r_product <= PW'(in_a) * PW'(in_b);
                end
            end
        end else begin : g_latn
            logic signed [OPERAND_BITS-1:0] r_a;
            logic signed [OPERAND_BITS-1:0] r_b;
            logic signed [PW-1:0]           w_last;

            // Issue register.
            always_ff @(posedge clk) begin
                if (in_valid) begin
                    r_a <= in_a;
                    r_b <= in_b;
                end
            end

            if (MULT_LATENCY == 2) begin : g_direct
                assign w_last = PW'(r_a) * PW'(r_b);
            end else begin : g_stages
                logic [MULT_LATENCY-3:0][PW-1:0] r_pipe;
                always_ff @(posedge clk) begin
                    r_pipe[0] <= PW'(r_a) * PW'(r_b);
                    for (int unsigned k = 1; k < MULT_LATENCY - 2; k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
                assign w_last = $signed(r_pipe[MULT_LATENCY-3]);
            end

            // Output stage loads only for a live result, so the bus holds
            // the previous product between strobes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_product <= '0;
                end else if (r_vld[MULT_LATENCY-2]) begin
                    r_product <= w_last;
                end
            end
        end
    endgenerate

    assign product   = r_product;
    assign out_valid = r_vld[MULT_LATENCY-1];
    assign out_id    = r_id[MULT_LATENCY-1];
    assign busy      = |r_vld;

endmodule
`default_nettype wire

// File: rtl/dsp_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_mult_arbiter
//  Description : Shares one pipelined signed multiplier between DSP
//                requesters. Round-robin arbitration with an optional bounded
//                burst lock; products return in issue order with a one-hot
//                owner strobe.
//  Ports       : clk, rst       DSP clock, synchronous active-high reset
//                req, lock      per-requester request / keep-grant request
//                op_a, op_b     per-requester signed operands
//                grant          one-hot grant, combinational
//                product        shared signed product bus
//                product_valid  one-hot owner strobe for product
//                busy           products in flight
//  Revision    : 1.0  initial release
// ============================================================================
module dsp_mult_arbiter
    import dsp_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned REQ_ID_BITS  = 1,
    parameter int unsigned OPERAND_BITS = DSP_OPERAND_BITS,
    parameter int unsigned PRODUCT_BITS = 2 * OPERAND_BITS,
    parameter int unsigned MULT_LATENCY = DSP_MULT_LATENCY,
    parameter int unsigned MAX_BURST    = 64,
    parameter int unsigned BURST_BITS   = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ-1:0]                    lock,
    input  logic [NUM_REQ-1:0][OPERAND_BITS-1:0]  op_a,
    input  logic [NUM_REQ-1:0][OPERAND_BITS-1:0]  op_b,
    output logic [NUM_REQ-1:0]                    grant,
    output logic [PRODUCT_BITS-1:0]               product,
    output logic [NUM_REQ-1:0]                    product_valid,
    output logic                                  busy
);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_t;

    arb_state_t               r_state;
    arb_state_t               w_state_nxt;
    logic [REQ_ID_BITS-1:0]   r_owner;
    logic [REQ_ID_BITS-1:0]   w_owner_nxt;
    logic [REQ_ID_BITS-1:0]   r_rr_ptr;
    logic [REQ_ID_BITS-1:0]   w_rr_ptr_nxt;
    logic [BURST_BITS-1:0]    r_burst_cnt;
    logic [BURST_BITS-1:0]    w_burst_cnt_nxt;
    logic [BURST_BITS-1:0]    w_cnt_inc;

    logic [DSP_MAX_REQ-1:0]   w_req_ext;
    logic [NUM_REQ-1:0]       w_grant;
    logic [REQ_ID_BITS-1:0]   w_gidx;
    logic [REQ_ID_BITS-1:0]   w_ptr_after;
    logic                     w_any_grant;

    logic signed [OPERAND_BITS-1:0]   w_sel_a;
    logic signed [OPERAND_BITS-1:0]   w_sel_b;
    logic signed [2*OPERAND_BITS-1:0] w_product;
    logic                             w_out_valid;
    logic [REQ_ID_BITS-1:0]           w_out_id;

    // ------------------------------------------------------------------
    // Arbitration and lock next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;

        w_req_ext                = '0;
        w_req_ext[NUM_REQ-1:0]   = req;

        w_grant = '0;
        if (!rst) begin
            if (r_state == LOCKED) begin
                // Only the owner may be granted; everyone else waits.
                w_grant[r_owner] = req[r_owner];
            end else begin
                w_grant = NUM_REQ'(rr_pick(w_req_ext, 32'(r_rr_ptr), NUM_REQ));
            end
        end

        w_gidx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = REQ_ID_BITS'(i);
            end
        end
        w_any_grant = |w_grant;
        w_ptr_after = (w_gidx == REQ_ID_BITS'(NUM_REQ - 1)) ? '0
                                                            : w_gidx + REQ_ID_BITS'(1);
        // While unlocked the counter is zero, so this is also the count for
        // the grant that opens a burst.
        w_cnt_inc   = r_burst_cnt + BURST_BITS'(1);

        if (w_any_grant) begin
            // Pointer always follows the latest grant, so a released burst
            // resumes round-robin from owner+1.
            w_rr_ptr_nxt = w_ptr_after;
            if (lock[w_gidx] && (w_cnt_inc != BURST_BITS'(MAX_BURST))) begin
                w_state_nxt     = LOCKED;
                w_owner_nxt     = w_gidx;
                w_burst_cnt_nxt = w_cnt_inc;
            end else begin
                w_state_nxt     = UNLOCKED;
                w_burst_cnt_nxt = '0;
            end
        end else if (r_state == LOCKED) begin
            // Owner went idle: drop the lock.
            w_state_nxt     = UNLOCKED;
            w_burst_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= UNLOCKED;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    assign grant = w_grant;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_sel_a = $signed(op_a[w_gidx]);
    assign w_sel_b = $signed(op_b[w_gidx]);

    mult_pipe #(
        .OPERAND_BITS (OPERAND_BITS),
        .MULT_LATENCY (MULT_LATENCY),
        .ID_BITS      (REQ_ID_BITS)
    ) u_mult_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_any_grant),
        .in_id     (w_gidx),
        .in_a      (w_sel_a),
        .in_b      (w_sel_b),
        .product   (w_product),
        .out_valid (w_out_valid),
        .out_id    (w_out_id),
        .busy      (busy)
    );

    assign product = w_product;

    always_comb begin
        product_valid = '0;
        if (w_out_valid) begin
            product_valid[w_out_id] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_mult_arbiter
//  Description : Directed self-checking bench for dsp_mult_arbiter with
//                NUM_REQ=2, MULT_LATENCY=3 and MAX_BURST=4. Inputs change
//                1 time unit after the rising edge; checks happen 1 unit
//                later, well clear of the next edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dsp_mult_arbiter;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req;
    logic [1:0]            lock;
    logic [1:0][17:0]      op_a;
    logic [1:0][17:0]      op_b;
    logic [1:0]            grant;
    logic [35:0]           product;
    logic [1:0]            product_valid;
    logic                  busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0]         exp_g2 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic signed [35:0] exp_p2 [4] = '{36'sd100, -36'sd200, 36'sd300, -36'sd400};
    logic [1:0]         exp_gb [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

    dsp_mult_arbiter #(
        .NUM_REQ      (2),
        .REQ_ID_BITS  (1),
        .OPERAND_BITS (18),
        .PRODUCT_BITS (36),
        .MULT_LATENCY (3),
        .MAX_BURST    (4),
        .BURST_BITS   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .lock          (lock),
        .op_a          (op_a),
        .op_b          (op_b),
        .grant         (grant),
        .product       (product),
        .product_valid (product_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_v(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_p(input string tag, input logic signed [35:0] obs,
                           input logic signed [35:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        cyc();
        rst  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        op_a = '0;
        op_b = '0;
        cyc();
        cyc();

        // ---- reset state, with requests present ----
        req = 2'b11;
        #1;
        check_v("rst_grant", grant, 2'b00);
        check_p("rst_product", $signed(product), 36'sd0);
        check_v("rst_pvalid", product_valid, 2'b00);
        check_b("rst_busy", busy, 1'b0);
        cyc();

        // ---- single request: 3 * -5 ----
        rst     = 1'b0;
        req     = 2'b01;
        op_a[0] = 18'sd3;
        op_b[0] = -18'sd5;
        #1;
        check_v("single_grant", grant, 2'b01);
        check_b("single_busy_t0", busy, 1'b0);
        cyc();
        req = 2'b00;
        #1;
        check_b("single_busy_t1", busy, 1'b1);
        check_v("single_pv_t1", product_valid, 2'b00);
        cyc();
        #1;
        check_b("single_busy_t2", busy, 1'b1);
        check_v("single_pv_t2", product_valid, 2'b00);
        cyc();
        #1;
        check_v("single_pv_t3", product_valid, 2'b01);
        check_p("single_prod_t3", $signed(product), -36'sd15);
        check_b("single_busy_t3", busy, 1'b1);
        cyc();
        #1;
        check_v("single_pv_t4", product_valid, 2'b00);
        check_p("single_hold_t4", $signed(product), -36'sd15);
        check_b("single_busy_t4", busy, 1'b0);

        // ---- contention without lock ----
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req     = (c < 4) ? 2'b11 : 2'b00;
            op_a[0] = 18'(c + 1);
            op_b[0] = 18'sd100;
            op_a[1] = 18'(c + 1);
            op_b[1] = -18'sd100;
            #1;
            if (c < 4) begin
                check_v($sformatf("cont_grant%0d", c), grant, exp_g2[c]);
            end
            if (c >= 3) begin
                check_v($sformatf("cont_pv%0d", c - 3), product_valid, exp_g2[c-3]);
                check_p($sformatf("cont_prod%0d", c - 3), $signed(product), exp_p2[c-3]);
            end
            cyc();
        end

        // ---- burst lock, MAX_BURST=4, starting with rr_ptr=1 ----
        do_reset();
        req = 2'b01;
        #1;
        check_v("burst_setup_grant", grant, 2'b01);
        cyc();
        req  = 2'b11;
        lock = 2'b10;
        for (int c = 0; c < 6; c++) begin
            #1;
            check_v($sformatf("burst_grant%0d", c), grant, exp_gb[c]);
            cyc();
        end
        req  = 2'b00;
        lock = 2'b00;

        // ---- lock released by deasserting lock on the 2nd grant ----
        do_reset();
        req  = 2'b11;
        lock = 2'b01;
        #1;
        check_v("rel_grant0", grant, 2'b01);
        cyc();
        lock = 2'b00;
        #1;
        check_v("rel_grant1", grant, 2'b01);
        cyc();
        #1;
        check_v("rel_grant2", grant, 2'b10);
        cyc();

        // ---- lock released by the owner going idle ----
        do_reset();
        req  = 2'b01;
        lock = 2'b01;
        #1;
        check_v("idle_grant0", grant, 2'b01);
        cyc();
        req  = 2'b00;
        lock = 2'b00;
        #1;
        check_v("idle_grant1", grant, 2'b00);
        cyc();
        req = 2'b11;
        #1;
        check_v("idle_grant2", grant, 2'b10);
        cyc();

        // ---- extreme operands, back to back ----
        do_reset();
        req     = 2'b01;
        op_a[0] = 18'h20000;
        op_b[0] = 18'h20000;
        #1;
        check_v("ext_grant0", grant, 2'b01);
        cyc();
        op_a[0] = 18'h1FFFF;
        op_b[0] = 18'h20000;
        #1;
        check_v("ext_grant1", grant, 2'b01);
        cyc();
        req = 2'b00;
        cyc();
        #1;
        check_v("ext_pv0", product_valid, 2'b01);
        check_p("ext_prod0", $signed(product), 36'sd17179869184);
        cyc();
        #1;
        check_v("ext_pv1", product_valid, 2'b01);
        check_p("ext_prod1", $signed(product), -36'sd17179738112);
        cyc();

        // ---- reset while operations are in flight ----
        do_reset();
        req     = 2'b01;
        op_a[0] = 18'sd5;
        op_b[0] = 18'sd6;
        #1;
        check_v("mid_grant0", grant, 2'b01);
        cyc();
        op_a[0] = 18'sd7;
        op_b[0] = 18'sd8;
        #1;
        check_v("mid_grant1", grant, 2'b01);
        cyc();
        rst = 1'b1;
        #1;
        check_v("mid_rst_grant", grant, 2'b00);
        cyc();
        rst = 1'b0;
        req = 2'b00;
        #1;
        check_b("mid_busy", busy, 1'b0);
        check_p("mid_product", $signed(product), 36'sd0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check_v($sformatf("mid_pv%0d", c), product_valid, 2'b00);
            cyc();
        end
        req = 2'b11;
        #1;
        check_v("mid_ptr_grant", grant, 2'b01);
        cyc();
        req = 2'b00;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
